pc_redirect_unit: RTL
=====================

// Module: pc_redirect_unit
// PURPOSE
//  Program-counter register and next-PC selector for the RISC-V core. Consumes the
//  should_branch result of the EX-stage branch comparator together with the decoded
//  jump/branch flags. It computes the target and redirects fetch, then generates a
//  multi-cycle flush of the younger in-flight instructions. It halts fetch on a
//  misaligned target.
// PARAMETERS
//  RESET_PC     32'h0000_0000  fetch address loaded by rst
//  FLUSH_SLOTS  2              number of pipeline advances killed after a redirect (>=1)
// PORTS
//  clk            in   1   core clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   hazard unit: pipeline frozen this cycle
//  ex_valid       in   1   EX stage holds a live instruction
//  ex_is_branch   in   1   EX instruction is a conditional branch (B-type)
//  ex_is_jal      in   1   EX instruction is JAL
//  ex_is_jalr     in   1   EX instruction is JALR
//  should_branch  in   1   branch comparator result for the EX instruction
//  ex_pc          in   32  PC of the EX instruction
//  ex_imm         in   32  sign-extended immediate of the EX instruction
//  ex_rs1         in   32  forwarded rs1 value (JALR base)
//  pc             out  32  current fetch address (registered)
//  pc_plus4       out  32  pc + 4, mod 2^32 (combinational)
//  redirect       out  1   taken control transfer accepted this cycle (combinational)
//  flush          out  1   kill IF/ID and ID/EX contents this cycle
//  misalign_err   out  1   sticky: a taken target had target[1:0] != 0
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=RUN, flush_cnt=0, misalign_err=0. redirect and flush are
//   forced to 0 while rst is high.
//  Target: JALR -> (ex_rs1+ex_imm) & ~32'h1; JAL or branch -> ex_pc+ex_imm.
//   All additions wrap mod 2^32.
//  Type priority when several flags are set: jalr > jal > branch.
//  taken = state==RUN & ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & should_branch)).
//  FSM states: RUN, FLUSH, HALT.
//   RUN, taken, target[1:0]==0:
//    - redirect=1 and flush=1 this cycle.
//    - pc<=target regardless of stall. The EX instruction is older than any stall cause.
//    - flush_cnt<=FLUSH_SLOTS-1.
//    - Next state is FLUSH if FLUSH_SLOTS>1, else RUN.
//   RUN, taken, misaligned target:
//    - misalign_err<=1, pc held, flush=1.
//    - Next state HALT. redirect stays 0.
//   RUN, not taken: pc<=pc_plus4 if !stall, else pc held.
//   FLUSH:
//    - flush=1.
//    - ex_valid and all type flags are ignored, because the EX instruction is a killed slot.
//    - pc<=pc_plus4 if !stall.
//    - flush_cnt decrements only when !stall.
//    - Return to RUN on the cycle flush_cnt==1 and !stall. flush is deasserted the next cycle.
//   HALT: pc frozen, flush=1 every cycle, misalign_err=1. Exit only via rst.
//  Latency: redirect to new pc is 1 cycle. The first fetch of the target occurs the cycle
//   after redirect.
//  Wrap: pc=32'hFFFF_FFFC with no redirect -> pc 32'h0000_0000, no error.
//  Reset mid-FLUSH or mid-HALT: the next cycle is the full reset state, with no residual flush.
// TESTING
//  T1 reset: rst 1 cycle with RESET_PC=32'h100 -> pc=0x100, flush=0, misalign_err=0; then
//     3 free cycles -> pc 0x104, 0x108, 0x10C.
//  T2 taken beq: ex_pc=0x200, ex_imm=0x40, should_branch=1 -> redirect=1, next pc=0x240;
//     flush high for 2 cycles; a taken flag injected in the 2nd cycle is ignored.
//  T3 jalr: ex_rs1=0x1001, ex_imm=0x4 -> pc=0x1004, bit0 cleared, no error.
//  T4 stall interplay: stall=1 with a taken jal at 0x300, imm 0x10 -> pc=0x310 anyway;
//     stall held 3 more cycles -> flush stays high, pc held at 0x310.
//  T5 misaligned: branch target 0x402 -> misalign_err=1, pc frozen, flush stuck high;
//     rst -> clean restart at RESET_PC.
//  T6 wrap: pc=0xFFFF_FFFC, no redirect -> pc=0x0; not-taken branch -> no flush.

Source files
------------

// File: rtl/pc_redirect_unit_if.sv
// Bundle between the pipeline and the PC redirect unit: EX-stage control-transfer
// inputs plus the fetch address, redirect and flush outputs.
interface pc_redirect_unit_if;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        should_branch;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        flush;
  logic        misalign_err;

  modport master (
    output stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, should_branch,
           ex_pc, ex_imm, ex_rs1,
    input  pc, pc_plus4, redirect, flush, misalign_err
  );

  modport slave (
    input  stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, should_branch,
           ex_pc, ex_imm, ex_rs1,
    output pc, pc_plus4, redirect, flush, misalign_err
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Program counter and next-PC selection: redirects fetch on taken EX-stage control
// transfers, flushes the younger slots afterwards and halts on a misaligned target.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FLUSH_SLOTS = 2
) (
  input logic            clk,
  input logic            rst,
  pc_redirect_unit_if.slave bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam int CW = $clog2(FLUSH_SLOTS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_SLOTS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [1:0] S_AFTER_REDIRECT = (FLUSH_SLOTS > 1) ? S_FLUSH : S_RUN;

  logic [1:0]    state;
  logic [CW-1:0] flush_cnt;
  logic [31:0]   pc_q;
  logic          err_q;

  logic [31:0] pc_plus4;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        taken;
  logic        misaligned;

  assign pc_plus4 = pc_q + 32'd4;
  assign jalr_sum = bus.ex_rs1 + bus.ex_imm;

  // jalr wins over jal/branch; jal and branch share the PC-relative target
  assign target = bus.ex_is_jalr ? {jalr_sum[31:1], 1'b0} : (bus.ex_pc + bus.ex_imm);

  assign taken = (state == S_RUN) && bus.ex_valid &&
                 (bus.ex_is_jalr || bus.ex_is_jal || (bus.ex_is_branch && bus.should_branch));
  assign misaligned = (target[1:0] != 2'b00);

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.misalign_err = err_q;
  assign bus.redirect     = !rst && taken && !misaligned;
  assign bus.flush        = !rst && (taken || (state == S_FLUSH) || (state == S_HALT));

  // A redirect moves pc even under stall: the EX instruction is older than any stall cause
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      state     <= S_RUN;
      flush_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (taken) begin
            if (misaligned) begin
              err_q <= 1'b1;
              state <= S_HALT;
            end else begin
              pc_q      <= target;
              flush_cnt <= CNT_LOAD;
              state     <= S_AFTER_REDIRECT;
            end
          end else if (!bus.stall) begin
            pc_q <= pc_plus4;
          end
        end
        S_FLUSH: begin
          if (!bus.stall) begin
            pc_q      <= pc_plus4;
            flush_cnt <= flush_cnt - CNT_ONE;
            if (flush_cnt == CNT_ONE) begin
              state <= S_RUN;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule
